// File: rtl/register_file_if.sv
// Bus bundle for register_file: operation strobes, addresses and write data in;
// registered read data and illegal-access flag out.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // Strobe semantics: READ and WRITE are sampled on every rising clock edge with
  // no ready/back-pressure. {READ,WRITE} = 00 idle, 10 read, 01 write, 11 illegal.
  // Read data appears on DATA_R1/DATA_R2 after the edge that sampled READ=1 and
  // holds until the next read edge or reset; ERR is high for one cycle after an
  // illegal edge.
  logic                  READ;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] ADDR_R1;
  logic [ADDR_WIDTH-1:0] ADDR_R2;
  logic [ADDR_WIDTH-1:0] ADDR_W;
  logic [DATA_WIDTH-1:0] DATA_W;
  logic [DATA_WIDTH-1:0] DATA_R1;
  logic [DATA_WIDTH-1:0] DATA_R2;
  logic                  ERR;

  modport master (
    output READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    input  DATA_R1, DATA_R2, ERR
  );

  modport slave (
    input  READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    output DATA_R1, DATA_R2, ERR
  );
endinterface

// File: rtl/register_file.sv
// Two-read / one-write register file with registered outputs, a synchronous
// active-low reset that clears every word, and a one-cycle illegal-access flag.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           C,
  input  logic           nR,
  register_file_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_r1;
  logic [DATA_WIDTH-1:0] r_data_r2;
  logic                  r_err;
  logic [1:0]            w_op;

  assign w_op = {bus.READ, bus.WRITE};

  // Reset wins over any operation; read and write never share an edge, so no bypass.
  always_ff @(posedge C) begin
    if (!nR) begin
      r_mem     <= '{default: '0};
      r_data_r1 <= '0;
      r_data_r2 <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (w_op)
        2'b10: begin
          r_data_r1 <= r_mem[bus.ADDR_R1];
          r_data_r2 <= r_mem[bus.ADDR_R2];
        end
        2'b01:   r_mem[bus.ADDR_W] <= bus.DATA_W;
        2'b11:   r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.DATA_R1 = r_data_r1;
  assign bus.DATA_R2 = r_data_r2;
  assign bus.ERR     = r_err;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, full write/read sweep, same-address
// read, illegal access, reset priority and idle hold.
module tb_register_file;

  logic C;
  logic nR;
  int   n_assert;
  int   n_fail;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .C  (C),
    .nR (nR),
    .bus(bus)
  );

  // Clock and reset
  initial C = 1'b0;
  always #5 C = ~C;

  // Driver tasks
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic drive_idle();
    bus.READ    = 1'b0;
    bus.WRITE   = 1'b0;
    bus.ADDR_R1 = '0;
    bus.ADDR_R2 = '0;
    bus.ADDR_W  = '0;
    bus.DATA_W  = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    bus.WRITE  = 1'b1;
    bus.ADDR_W = a;
    bus.DATA_W = d;
    tick();
    bus.WRITE  = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
    bus.READ    = 1'b1;
    bus.ADDR_R1 = a1;
    bus.ADDR_R2 = a2;
    tick();
    bus.READ    = 1'b0;
  endtask

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] e1;
    logic [31:0] e2;
    n_assert = 0;
    n_fail   = 0;
    drive_idle();

    // Reset, then read words 0 and 31
    nR = 1'b0;
    tick();
    nR = 1'b1;
    check("rst_r1", bus.DATA_R1, 32'h0);
    check("rst_r2", bus.DATA_R2, 32'h0);
    check("rst_err", {31'b0, bus.ERR}, 32'h0);
    do_read(5'd0, 5'd31);
    check("rst_rd_r1", bus.DATA_R1, 32'h0);
    check("rst_rd_r2", bus.DATA_R2, 32'h0);
    check("rst_rd_err", {31'b0, bus.ERR}, 32'h0);

    // Write every word, then read mirrored pairs
    for (int i = 0; i < 32; i++) begin
      do_write(5'(i), 32'(i) * 32'h01010101);
    end
    check("wr_hold_r1", bus.DATA_R1, 32'h0);
    check("wr_hold_r2", bus.DATA_R2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      e1 = 32'(i) * 32'h01010101;
      e2 = 32'(31 - i) * 32'h01010101;
      do_read(5'(i), 5'(31 - i));
      check($sformatf("sweep_r1_%0d", i), bus.DATA_R1, e1);
      check($sformatf("sweep_r2_%0d", i), bus.DATA_R2, e2);
    end
    check("sweep_err", {31'b0, bus.ERR}, 32'h0);

    // Address 0 is an ordinary word
    do_write(5'd0, 32'h55AA55AA);
    do_read(5'd0, 5'd31);
    check("addr0_r1", bus.DATA_R1, 32'h55AA55AA);
    check("addr0_r2", bus.DATA_R2, 32'h1F1F1F1F);

    // Same-address read on both ports
    do_write(5'd7, 32'hDEADBEEF);
    do_read(5'd7, 5'd7);
    check("same_r1", bus.DATA_R1, 32'hDEADBEEF);
    check("same_r2", bus.DATA_R2, 32'hDEADBEEF);

    // Illegal access: outputs hold, ERR for one cycle, no write to word 3
    do_write(5'd10, 32'h12345678);
    do_read(5'd10, 5'd10);
    check("ill_pre_r1", bus.DATA_R1, 32'h12345678);
    bus.READ    = 1'b1;
    bus.WRITE   = 1'b1;
    bus.ADDR_W  = 5'd3;
    bus.DATA_W  = 32'hFFFFFFFF;
    bus.ADDR_R1 = 5'd3;
    bus.ADDR_R2 = 5'd0;
    tick();
    drive_idle();
    check("ill_err", {31'b0, bus.ERR}, 32'h1);
    check("ill_r1", bus.DATA_R1, 32'h12345678);
    check("ill_r2", bus.DATA_R2, 32'h12345678);
    tick();
    check("ill_err_clr", {31'b0, bus.ERR}, 32'h0);
    check("ill_r1_hold", bus.DATA_R1, 32'h12345678);
    do_read(5'd3, 5'd3);
    check("ill_word3", bus.DATA_R1, 32'h03030303);

    // Reset priority over a write on the same edge, and full clear mid-sequence
    nR          = 1'b0;
    bus.WRITE   = 1'b1;
    bus.ADDR_W  = 5'd5;
    bus.DATA_W  = 32'hA5A5A5A5;
    tick();
    nR = 1'b1;
    drive_idle();
    check("rp_r1", bus.DATA_R1, 32'h0);
    check("rp_err", {31'b0, bus.ERR}, 32'h0);
    do_read(5'd5, 5'd7);
    check("rp_word5", bus.DATA_R1, 32'h0);
    check("rp_word7", bus.DATA_R2, 32'h0);

    // Hold through idle edges
    do_write(5'd9, 32'hCAFEF00D);
    check("hold_wr_nochg", bus.DATA_R1, 32'h0);
    do_read(5'd9, 5'd5);
    check("hold_rd", bus.DATA_R1, 32'hCAFEF00D);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("hold_r1_%0d", k), bus.DATA_R1, 32'hCAFEF00D);
      check($sformatf("hold_err_%0d", k), {31'b0, bus.ERR}, 32'h0);
    end

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
